ro_puf_evaluator: RTL and testbench
===================================

# ro_puf_evaluator

Parametrised ring-oscillator PUF measurement engine: gates a bank of NUM_RO free-running ring oscillators, selects a challenge pair, counts rising edges of both over a fixed clock window, and returns a one-bit response plus raw counts. It is the next generation of the single three-slice oscillator: that block becomes one channel of RO_IN, and this block supplies enables, measurement, and a start/valid handshake toward the encryption/key logic.

## Interface
- NUM_RO, 16: number of oscillator channels (≥2)
- CNT_W, 16: edge-counter width
- WINDOW, 4096: counting window in CLK cycles (≥1)
- SYNC_STAGES, 2: synchroniser flops per sampled channel (≥2)
- CLK  in  1  system clock
- RST  in  1  reset; one clock; reset is asynchronous and active-high
- START  in  1  request a measurement; sampled only in IDLE or DONE
- CHAL_A  in  $clog2(NUM_RO)  first oscillator index
- CHAL_B  in  $clog2(NUM_RO)  second oscillator index
- RO_IN  in  NUM_RO  raw oscillator outputs (asynchronous to CLK)
- RO_EN  out  NUM_RO  per-oscillator enable
- BUSY  out  1  measurement in progress
- VALID  out  1  RESP/CNT_A/CNT_B/SAT/ERR are valid
- RESP  out  1  1 iff CNT_A > CNT_B
- CNT_A, CNT_B  out  CNT_W  edge counts of the selected pair
- SAT  out  1  either counter saturated
- ERR  out  1  CHAL_A == CHAL_B or index ≥ NUM_RO

## Operation
- FSM states: IDLE, ARM, COUNT, DRAIN, DONE.
- IDLE/DONE + START=1: latch CHAL_A/CHAL_B; clear counters, SAT, ERR; VALID←0.
  - Illegal challenge (equal or out of range): go to DONE next cycle with ERR=1, RESP=0, counts 0, no RO enabled.
  - Otherwise go to ARM.
- ARM: SYNC_STAGES+1 cycles; RO_EN bits for the latched pair = 1, all others 0; synchronisers fill; detected edges discarded.
- COUNT: WINDOW cycles; RO_EN held; every rising edge of each synchronised selected channel (sync_last & ~prev) increments its counter.
- DRAIN: SYNC_STAGES+1 cycles; RO_EN = 0; counting continues so in-flight edges are captured.
- DONE: VALID=1; RESP = (CNT_A > CNT_B), tie → 0; outputs held until the next accepted START or RST.
- Selected channels are muxed from RO_IN by the latched indices, then synchronised; unselected channels are never sampled.
- Counters saturate at 2^CNT_W−1 (no wrap); SAT=1 if either saturates.
- Measurement is correct only for oscillator frequency < CLK/2; faster channels undercount (aliasing), not flagged.
- START while BUSY: ignored, no effect on latched challenge.
- CHAL changes after START acceptance: no effect.

## Timing
- RST asserted (any time, incl. mid-measurement): FSM→IDLE, RO_EN=0, BUSY=0, VALID=0, RESP=0, CNT_A=CNT_B=0, SAT=0, ERR=0, synchronisers cleared; takes effect without a clock edge.
- START sampled high at edge t: BUSY=1 and RO_EN asserted from t+1.
- COUNT occupies cycles t+1+(SYNC_STAGES+1) … +WINDOW−1.
- VALID rises at t+1+2·(SYNC_STAGES+1)+WINDOW (defaults: t+4103); BUSY falls the same cycle.
- Illegal challenge: VALID=1, ERR=1 at t+1.
- START in DONE at edge t: VALID=0 at t+1 (back-to-back measurements allowed, no idle gap required).
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- WINDOW=64, CHAL_A=3, CHAL_B=7; RO_IN[3] period 4 CLK, RO_IN[7] period 8 CLK → VALID at t+71, CNT_A=16±1, CNT_B=8±1, RESP=1, SAT=0, ERR=0; RO_EN=0x0088 only during ARM/COUNT.
- Same setup, swap channels (CHAL_A=7, CHAL_B=3) → RESP=0; identical periods on both → |CNT_A−CNT_B|≤1 and RESP=0 when equal.
- CNT_W=4, WINDOW=64, channel period 2 CLK → CNT_A=15, SAT=1, no wrap.
- CHAL_A=CHAL_B=5 → VALID and ERR at t+1, RESP=0, counts 0, RO_EN stays 0; CHAL_A=NUM_RO (out of range, NUM_RO non-power-of-two config) → same.
- RST pulsed mid-COUNT → all outputs 0 immediately, FSM IDLE; subsequent START produces a full, correct measurement.
- START pulsed repeatedly during BUSY with changing CHAL → ignored; result matches original challenge; START in DONE restarts with VALID dropping next cycle.

Source files
------------

// File: rtl/ro_puf_evaluator.sv
// Ring-oscillator PUF evaluator: enables a challenge pair, counts synchronised rising
// edges of both over a fixed clock window and reports which oscillator ran faster.
module ro_puf_evaluator #(
    parameter int NUM_RO      = 16,
    parameter int CNT_W       = 16,
    parameter int WINDOW      = 4096,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      START,
    input  logic [$clog2(NUM_RO)-1:0] CHAL_A,
    input  logic [$clog2(NUM_RO)-1:0] CHAL_B,
    input  logic [NUM_RO-1:0]         RO_IN,
    output logic [NUM_RO-1:0]         RO_EN,
    output logic                      BUSY,
    output logic                      VALID,
    output logic                      RESP,
    output logic [CNT_W-1:0]          CNT_A,
    output logic [CNT_W-1:0]          CNT_B,
    output logic                      SAT,
    output logic                      ERR
);

    localparam int IDX_W = $clog2(NUM_RO);
    localparam int TMR_W = $clog2(WINDOW + SYNC_STAGES + 2);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SYNC_STAGES);
    localparam logic [TMR_W-1:0] WIN_LAST    = TMR_W'(WINDOW - 1);
    localparam logic [IDX_W:0]   RO_LIMIT    = (IDX_W + 1)'(NUM_RO);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [2:0] {IDLE, ARM, COUNT, DRAIN, DONE} state_t;

    state_t                 state;
    logic [TMR_W-1:0]       tmr;
    logic [IDX_W-1:0]       sel_a;
    logic [IDX_W-1:0]       sel_b;
    logic [SYNC_STAGES-1:0] sync_a;
    logic [SYNC_STAGES-1:0] sync_b;
    logic                   prev_a;
    logic                   prev_b;
    logic                   rise_a;
    logic                   rise_b;
    logic                   counting;
    logic                   illegal;
    logic [CNT_W-1:0]       cnt_a_nxt;
    logic [CNT_W-1:0]       cnt_b_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != CNT_MAX))
            return v + CNT_W'(1);
        return v;
    endfunction

    function automatic logic [NUM_RO-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_RO-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    always_comb begin
        rise_a    = sync_a[SYNC_STAGES-1] & ~prev_a;
        rise_b    = sync_b[SYNC_STAGES-1] & ~prev_b;
        counting  = (state == COUNT) || (state == DRAIN);
        cnt_a_nxt = sat_inc(CNT_A, counting & rise_a);
        cnt_b_nxt = sat_inc(CNT_B, counting & rise_b);
        illegal   = (CHAL_A == CHAL_B) || ({1'b0, CHAL_A} >= RO_LIMIT)
                    || ({1'b0, CHAL_B} >= RO_LIMIT);
    end

    // Only the two latched channels are muxed in and synchronised.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_a <= '0;
            sync_b <= '0;
            prev_a <= 1'b0;
            prev_b <= 1'b0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], RO_IN[sel_a]};
            sync_b <= {sync_b[SYNC_STAGES-2:0], RO_IN[sel_b]};
            prev_a <= sync_a[SYNC_STAGES-1];
            prev_b <= sync_b[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            tmr   <= '0;
            sel_a <= '0;
            sel_b <= '0;
            RO_EN <= '0;
            BUSY  <= 1'b0;
            VALID <= 1'b0;
            RESP  <= 1'b0;
            CNT_A <= '0;
            CNT_B <= '0;
            SAT   <= 1'b0;
            ERR   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (START) begin
                        CNT_A <= '0;
                        CNT_B <= '0;
                        SAT   <= 1'b0;
                        RESP  <= 1'b0;
                        tmr   <= '0;
                        if (illegal) begin
                            state <= DONE;
                            VALID <= 1'b1;
                            ERR   <= 1'b1;
                            BUSY  <= 1'b0;
                            RO_EN <= '0;
                        end else begin
                            state <= ARM;
                            sel_a <= CHAL_A;
                            sel_b <= CHAL_B;
                            VALID <= 1'b0;
                            ERR   <= 1'b0;
                            BUSY  <= 1'b1;
                            RO_EN <= onehot(CHAL_A) | onehot(CHAL_B);
                        end
                    end
                end
                ARM: begin
                    // Synchronisers fill here; edges seen now are not counted.
                    if (tmr == SETTLE_LAST) begin
                        tmr   <= '0;
                        state <= COUNT;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                COUNT: begin
                    CNT_A <= cnt_a_nxt;
                    CNT_B <= cnt_b_nxt;
                    SAT   <= SAT | (cnt_a_nxt == CNT_MAX) | (cnt_b_nxt == CNT_MAX);
                    if (tmr == WIN_LAST) begin
                        tmr   <= '0;
                        state <= DRAIN;
                        RO_EN <= '0;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                DRAIN: begin
                    // Oscillators are off; edges still in the synchronisers land now.
                    CNT_A <= cnt_a_nxt;
                    CNT_B <= cnt_b_nxt;
                    SAT   <= SAT | (cnt_a_nxt == CNT_MAX) | (cnt_b_nxt == CNT_MAX);
                    if (tmr == SETTLE_LAST) begin
                        tmr   <= '0;
                        state <= DONE;
                        BUSY  <= 1'b0;
                        VALID <= 1'b1;
                        RESP  <= (cnt_a_nxt > cnt_b_nxt);
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ro_puf_evaluator.sv
// Bench for ro_puf_evaluator: gated behavioural oscillators drive two configurations,
// results are judged against edge counts expected from each oscillator's period.
`timescale 1ns/100ps
module tb_ro_puf_evaluator;

    localparam int CLK_NS = 10;
    localparam int M_N = 16, M_W = 16, M_WIN = 64, M_SS = 2;
    localparam int S_N = 12, S_W = 4,  S_WIN = 64, S_SS = 3;
    localparam int M_LAT = 2 * (M_SS + 1) + M_WIN;
    localparam int S_LAT = 2 * (S_SS + 1) + S_WIN;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic           m_start, m_busy, m_valid, m_resp, m_sat, m_err;
    logic [3:0]     m_chal_a, m_chal_b;
    logic [M_N-1:0] m_ro_in, m_ro_en;
    logic [M_W-1:0] m_cnt_a, m_cnt_b;

    logic           s_start, s_busy, s_valid, s_resp, s_sat, s_err;
    logic [3:0]     s_chal_a, s_chal_b;
    logic [S_N-1:0] s_ro_in, s_ro_en;
    logic [S_W-1:0] s_cnt_a, s_cnt_b;

    int m_hp [M_N];
    int m_ph [M_N];
    int s_hp [S_N];
    int s_ph [S_N];

    int checks = 0;
    int failures = 0;

    logic           ob_busy1, ob_valid1, ob_busy_end;
    logic [M_N-1:0] ob_en1, ob_en_mid, ob_en_end;
    int             ob_lat;

    ro_puf_evaluator #(.NUM_RO(M_N), .CNT_W(M_W), .WINDOW(M_WIN), .SYNC_STAGES(M_SS)) dut_m (
        .CLK(clk), .RST(rst), .START(m_start), .CHAL_A(m_chal_a), .CHAL_B(m_chal_b),
        .RO_IN(m_ro_in), .RO_EN(m_ro_en), .BUSY(m_busy), .VALID(m_valid), .RESP(m_resp),
        .CNT_A(m_cnt_a), .CNT_B(m_cnt_b), .SAT(m_sat), .ERR(m_err));

    ro_puf_evaluator #(.NUM_RO(S_N), .CNT_W(S_W), .WINDOW(S_WIN), .SYNC_STAGES(S_SS)) dut_s (
        .CLK(clk), .RST(rst), .START(s_start), .CHAL_A(s_chal_a), .CHAL_B(s_chal_b),
        .RO_IN(s_ro_in), .RO_EN(s_ro_en), .BUSY(s_busy), .VALID(s_valid), .RESP(s_resp),
        .CNT_A(s_cnt_a), .CNT_B(s_cnt_b), .SAT(s_sat), .ERR(s_err));

    // Oscillators: half-period in ns, run only while enabled, rest low when disabled.
    initial begin
        m_ro_in = '0;
        s_ro_in = '0;
        #0.5;
        forever begin
            for (int i = 0; i < M_N; i++) begin
                if (m_ro_en[i] === 1'b1 && m_hp[i] > 0) begin
                    m_ph[i]++;
                    if (m_ph[i] >= m_hp[i]) begin m_ph[i] = 0; m_ro_in[i] = ~m_ro_in[i]; end
                end else begin
                    m_ph[i] = 0; m_ro_in[i] = 1'b0;
                end
            end
            for (int i = 0; i < S_N; i++) begin
                if (s_ro_en[i] === 1'b1 && s_hp[i] > 0) begin
                    s_ph[i]++;
                    if (s_ph[i] >= s_hp[i]) begin s_ph[i] = 0; s_ro_in[i] = ~s_ro_in[i]; end
                end else begin
                    s_ph[i] = 0; s_ro_in[i] = 1'b0;
                end
            end
            #1;
        end
    end

    // Reference: edges of period 2*hp ns inside a window of WINDOW cycles plus the
    // synchroniser slack that the drain phase recovers.
    function automatic int cnt_lo(input int hp, input int win);
        int p;
        p = 2 * hp;
        return (win * CLK_NS + p - 1) / p - 1;
    endfunction

    function automatic int cnt_hi(input int hp, input int win, input int ss);
        int p;
        p = 2 * hp;
        return ((win + ss + 1) * CLK_NS) / p + 1;
    endfunction

    task automatic do_measure(input int a, input int b, input bit noise);
        m_chal_a = 4'(a);
        m_chal_b = 4'(b);
        m_start  = 1'b1;
        @(posedge clk); #1;
        m_start   = 1'b0;
        ob_busy1  = m_busy;
        ob_valid1 = m_valid;
        ob_en1    = m_ro_en;
        ob_en_mid = '0;
        ob_lat    = 0;
        for (int n = 1; n <= 200; n++) begin
            if (noise) begin
                m_start  = 1'($urandom_range(0, 1));
                m_chal_a = 4'($urandom);
                m_chal_b = 4'($urandom);
            end
            @(posedge clk); #1;
            if (n == (M_SS + 1) + M_WIN / 2) ob_en_mid = m_ro_en;
            if (m_valid === 1'b1) begin ob_lat = n; break; end
        end
        m_start     = 1'b0;
        ob_busy_end = m_busy;
        ob_en_end   = m_ro_en;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_start = 1'b0; m_chal_a = '0; m_chal_b = '0;
        s_start = 1'b0; s_chal_a = '0; s_chal_b = '0;
        #2;
        checks++;
        if ({m_busy, m_valid, m_resp, m_sat, m_err, m_ro_en, m_cnt_a, m_cnt_b} !== 53'd0) begin
            failures++;
            $display("FAIL reset_main outputs got=%h want=0",
                     {m_busy, m_valid, m_resp, m_sat, m_err, m_ro_en, m_cnt_a, m_cnt_b});
        end
        checks++;
        if ({s_busy, s_valid, s_resp, s_sat, s_err, s_ro_en, s_cnt_a, s_cnt_b} !== 25'd0) begin
            failures++;
            $display("FAIL reset_small outputs got=%h want=0",
                     {s_busy, s_valid, s_resp, s_sat, s_err, s_ro_en, s_cnt_a, s_cnt_b});
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({m_busy, m_valid, m_ro_en} !== 18'd0) begin
            failures++;
            $display("FAIL reset_idle got=%h want=0", {m_busy, m_valid, m_ro_en});
        end
    endtask

    task automatic test_basic();
        m_hp[3] = 20; m_hp[7] = 40;
        do_measure(3, 7, 1'b0);
        checks++;
        if (ob_busy1 !== 1'b1 || ob_valid1 !== 1'b0 || ob_en1 !== 16'h0088) begin
            failures++;
            $display("FAIL basic_start busy=%b valid=%b en=%h want busy=1 valid=0 en=0088",
                     ob_busy1, ob_valid1, ob_en1);
        end
        checks++;
        if (ob_en_mid !== 16'h0088) begin
            failures++; $display("FAIL basic_en_mid got=%h want=0088", ob_en_mid);
        end
        checks++;
        if (ob_lat !== M_LAT) begin
            failures++; $display("FAIL basic_latency got=%0d want=%0d", ob_lat, M_LAT);
        end
        checks++;
        if (ob_busy_end !== 1'b0 || ob_en_end !== 16'h0000) begin
            failures++; $display("FAIL basic_end busy=%b en=%h want 0/0000", ob_busy_end, ob_en_end);
        end
        checks++;
        if (int'(m_cnt_a) < cnt_lo(20, M_WIN) || int'(m_cnt_a) > cnt_hi(20, M_WIN, M_SS)) begin
            failures++;
            $display("FAIL basic_cnt_a got=%0d want=%0d..%0d", m_cnt_a, cnt_lo(20, M_WIN), cnt_hi(20, M_WIN, M_SS));
        end
        checks++;
        if (int'(m_cnt_b) < cnt_lo(40, M_WIN) || int'(m_cnt_b) > cnt_hi(40, M_WIN, M_SS)) begin
            failures++;
            $display("FAIL basic_cnt_b got=%0d want=%0d..%0d", m_cnt_b, cnt_lo(40, M_WIN), cnt_hi(40, M_WIN, M_SS));
        end
        checks++;
        if ({m_resp, m_sat, m_err} !== 3'b100) begin
            failures++; $display("FAIL basic_flags resp/sat/err got=%b want=100", {m_resp, m_sat, m_err});
        end
    endtask

    task automatic test_back_to_back_swap();
        do_measure(7, 3, 1'b0);
        checks++;
        if (ob_valid1 !== 1'b0 || ob_busy1 !== 1'b1) begin
            failures++; $display("FAIL b2b_restart valid=%b busy=%b want 0/1", ob_valid1, ob_busy1);
        end
        checks++;
        if (int'(m_cnt_a) < cnt_lo(40, M_WIN) || int'(m_cnt_a) > cnt_hi(40, M_WIN, M_SS)
            || int'(m_cnt_b) < cnt_lo(20, M_WIN) || int'(m_cnt_b) > cnt_hi(20, M_WIN, M_SS)) begin
            failures++; $display("FAIL swap_counts got a=%0d b=%0d want a~8 b~16", m_cnt_a, m_cnt_b);
        end
        checks++;
        if (m_resp !== 1'b0 || ob_lat !== M_LAT) begin
            failures++; $display("FAIL swap_resp resp=%b lat=%0d want 0/%0d", m_resp, ob_lat, M_LAT);
        end
    endtask

    task automatic test_equal_periods();
        int hp;
        hp = $urandom_range(15, 40);
        m_hp[9] = hp; m_hp[12] = hp;
        do_measure(9, 12, 1'b0);
        checks++;
        if (int'(m_cnt_a) - int'(m_cnt_b) > 1 || int'(m_cnt_b) - int'(m_cnt_a) > 1
            || int'(m_cnt_a) < cnt_lo(hp, M_WIN) || int'(m_cnt_a) > cnt_hi(hp, M_WIN, M_SS)) begin
            failures++;
            $display("FAIL equal_counts got a=%0d b=%0d want both %0d..%0d within 1",
                     m_cnt_a, m_cnt_b, cnt_lo(hp, M_WIN), cnt_hi(hp, M_WIN, M_SS));
        end
        checks++;
        if (m_resp !== (m_cnt_a > m_cnt_b)) begin
            failures++; $display("FAIL equal_resp got=%b want=%b", m_resp, (m_cnt_a > m_cnt_b));
        end
    endtask

    task automatic test_illegal_equal();
        m_chal_a = 4'd5; m_chal_b = 4'd5; m_start = 1'b1;
        @(posedge clk); #1;
        m_start = 1'b0;
        checks++;
        if (m_valid !== 1'b1 || m_err !== 1'b1 || m_busy !== 1'b0) begin
            failures++;
            $display("FAIL illegal_flags valid=%b err=%b busy=%b want 1/1/0", m_valid, m_err, m_busy);
        end
        checks++;
        if ({m_resp, m_sat, m_ro_en, m_cnt_a, m_cnt_b} !== 50'd0) begin
            failures++;
            $display("FAIL illegal_clear got=%h want=0", {m_resp, m_sat, m_ro_en, m_cnt_a, m_cnt_b});
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b1 || m_err !== 1'b1 || m_ro_en !== 16'h0000) begin
            failures++;
            $display("FAIL illegal_hold valid=%b err=%b en=%h want 1/1/0000", m_valid, m_err, m_ro_en);
        end
    endtask

    task automatic test_ignore_start();
        do_measure(3, 7, 1'b1);
        checks++;
        if (ob_lat !== M_LAT || m_err !== 1'b0 || m_resp !== 1'b1) begin
            failures++;
            $display("FAIL ignore_result lat=%0d err=%b resp=%b want %0d/0/1", ob_lat, m_err, m_resp, M_LAT);
        end
        checks++;
        if (int'(m_cnt_a) < cnt_lo(20, M_WIN) || int'(m_cnt_a) > cnt_hi(20, M_WIN, M_SS)
            || int'(m_cnt_b) < cnt_lo(40, M_WIN) || int'(m_cnt_b) > cnt_hi(40, M_WIN, M_SS)) begin
            failures++; $display("FAIL ignore_counts got a=%0d b=%0d want a~16 b~8", m_cnt_a, m_cnt_b);
        end
    endtask

    task automatic test_random();
        int a, b, ha, hb;
        logic exp_resp;
        for (int k = 0; k < 5; k++) begin
            a  = $urandom_range(0, 15);
            b  = (a + $urandom_range(1, 15)) % 16;
            ha = $urandom_range(11, 60);
            hb = $urandom_range(11, 60);
            m_hp[a] = ha; m_hp[b] = hb;
            do_measure(a, b, 1'b0);
            checks++;
            if (ob_lat !== M_LAT) begin
                failures++; $display("FAIL rand_latency got=%0d want=%0d", ob_lat, M_LAT);
            end
            checks++;
            if (int'(m_cnt_a) < cnt_lo(ha, M_WIN) || int'(m_cnt_a) > cnt_hi(ha, M_WIN, M_SS)) begin
                failures++;
                $display("FAIL rand_cnt_a ch=%0d got=%0d want=%0d..%0d", a, m_cnt_a, cnt_lo(ha, M_WIN), cnt_hi(ha, M_WIN, M_SS));
            end
            checks++;
            if (int'(m_cnt_b) < cnt_lo(hb, M_WIN) || int'(m_cnt_b) > cnt_hi(hb, M_WIN, M_SS)) begin
                failures++;
                $display("FAIL rand_cnt_b ch=%0d got=%0d want=%0d..%0d", b, m_cnt_b, cnt_lo(hb, M_WIN), cnt_hi(hb, M_WIN, M_SS));
            end
            if (ha * 3 <= hb * 2)      exp_resp = 1'b1;
            else if (hb * 3 <= ha * 2) exp_resp = 1'b0;
            else                       exp_resp = (m_cnt_a > m_cnt_b);
            checks++;
            if (m_resp !== exp_resp || m_sat !== 1'b0) begin
                failures++;
                $display("FAIL rand_resp hpa=%0d hpb=%0d got resp=%b sat=%b want %b/0", ha, hb, m_resp, m_sat, exp_resp);
            end
        end
    endtask

    task automatic test_reset_mid();
        m_hp[1] = 20; m_hp[2] = 30;
        m_chal_a = 4'd1; m_chal_b = 4'd2; m_start = 1'b1;
        @(posedge clk); #1;
        m_start = 1'b0;
        repeat (30) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({m_busy, m_valid, m_resp, m_sat, m_err, m_ro_en, m_cnt_a, m_cnt_b} !== 53'd0) begin
            failures++;
            $display("FAIL reset_mid outputs got=%h want=0",
                     {m_busy, m_valid, m_resp, m_sat, m_err, m_ro_en, m_cnt_a, m_cnt_b});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_measure(1, 2, 1'b0);
        checks++;
        if (ob_lat !== M_LAT || m_resp !== 1'b1 || m_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_recover lat=%0d resp=%b err=%b want %0d/1/0", ob_lat, m_resp, m_err, M_LAT);
        end
        checks++;
        if (int'(m_cnt_a) < cnt_lo(20, M_WIN) || int'(m_cnt_a) > cnt_hi(20, M_WIN, M_SS)
            || int'(m_cnt_b) < cnt_lo(30, M_WIN) || int'(m_cnt_b) > cnt_hi(30, M_WIN, M_SS)) begin
            failures++; $display("FAIL reset_recover_counts got a=%0d b=%0d want a~16 b~11", m_cnt_a, m_cnt_b);
        end
    endtask

    task automatic test_saturation();
        int lat;
        s_hp[2] = 11; s_hp[5] = 50;
        s_chal_a = 4'd2; s_chal_b = 4'd5; s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        lat = 0;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk); #1;
            if (s_valid === 1'b1) begin lat = n; break; end
        end
        checks++;
        if (lat !== S_LAT) begin
            failures++; $display("FAIL sat_latency got=%0d want=%0d", lat, S_LAT);
        end
        checks++;
        if (s_cnt_a !== 4'd15 || s_sat !== 1'b1) begin
            failures++; $display("FAIL sat_count got cnt=%0d sat=%b want 15/1", s_cnt_a, s_sat);
        end
        checks++;
        if (int'(s_cnt_b) < cnt_lo(50, S_WIN) || int'(s_cnt_b) > cnt_hi(50, S_WIN, S_SS)) begin
            failures++;
            $display("FAIL sat_cnt_b got=%0d want=%0d..%0d", s_cnt_b, cnt_lo(50, S_WIN), cnt_hi(50, S_WIN, S_SS));
        end
        checks++;
        if ({s_resp, s_err, s_busy, s_ro_en} !== {3'b100, 12'h000}) begin
            failures++; $display("FAIL sat_flags got=%h want=%h", {s_resp, s_err, s_busy, s_ro_en}, {3'b100, 12'h000});
        end
    endtask

    task automatic test_out_of_range();
        s_chal_a = 4'd12; s_chal_b = 4'd3; s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        checks++;
        if (s_valid !== 1'b1 || s_err !== 1'b1) begin
            failures++; $display("FAIL range_flags valid=%b err=%b want 1/1", s_valid, s_err);
        end
        checks++;
        if ({s_busy, s_resp, s_sat, s_ro_en, s_cnt_a, s_cnt_b} !== 23'd0) begin
            failures++;
            $display("FAIL range_clear got=%h want=0", {s_busy, s_resp, s_sat, s_ro_en, s_cnt_a, s_cnt_b});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back_swap();
        test_equal_periods();
        test_illegal_equal();
        test_ignore_start();
        test_random();
        test_reset_mid();
        test_saturation();
        test_out_of_range();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
